// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcode
// classes and codes, flag bit positions, PC and ALU source selects.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    // Class is opcode[5:3]; LOAD/STORE/JAL/HALT are matched on the full code.
    localparam logic [2:0] CLS_R_ALU  = 3'b000;
    localparam logic [2:0] CLS_I_ALU  = 3'b001;
    localparam logic [2:0] CLS_BRANCH = 3'b100;

    localparam logic [5:0] OPC_LOAD  = 6'b010000;
    localparam logic [5:0] OPC_STORE = 6'b011000;
    localparam logic [5:0] OPC_JAL   = 6'b101000;
    localparam logic [5:0] OPC_HALT  = 6'b111111;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_SIGN  = 1;
    localparam int FLAG_CARRY = 2;

    localparam logic [1:0] PCSRC_INC    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUSRC_REG = 2'b00;
    localparam logic [1:0] ALUSRC_IMM = 2'b01;
    localparam logic [2:0] ALUOP_ADD  = 3'b000;

    typedef enum logic [2:0] {
        K_R_ALU, K_I_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_HALT, K_ILLEGAL
    } op_kind_e;

    function automatic op_kind_e classify(input logic [5:0] op);
        if (op[5:3] == CLS_R_ALU)       return K_R_ALU;
        else if (op[5:3] == CLS_I_ALU)  return K_I_ALU;
        else if (op[5:3] == CLS_BRANCH) return K_BRANCH;
        else if (op == OPC_LOAD)        return K_LOAD;
        else if (op == OPC_STORE)       return K_STORE;
        else if (op == OPC_JAL)         return K_JAL;
        else if (op == OPC_HALT)        return K_HALT;
        else                            return K_ILLEGAL;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: cc 00 always, 01 zero, 10 sign, 11 carry.
module branch_cond_eval
    import cpu_ctrl_pkg::*;
(
    input  logic [1:0] cc,
    input  logic [2:0] flags,
    output logic       taken
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        taken = 1'b0;
        case (cc)
            2'b00:   taken = 1'b1;
            2'b01:   taken = flags[FLAG_ZERO];
            2'b10:   taken = flags[FLAG_SIGN];
            2'b11:   taken = flags[FLAG_CARRY];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing,
// PC-update controls, memory-ready wait with timeout, sticky fault flags.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W         = 6,
    parameter int ALUOP_W      = 3,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic [2:0]         flags,
    input  logic               mem_ready,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               DataPCSel,
    output logic               RegSelect,
    output logic [ALUOP_W-1:0] ALUop,
    output logic [1:0]         ALUinSel,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         PCSrc,
    output logic               halted,
    output logic               illegal_op,
    output logic               bus_error
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;

    op_kind_e dec_kind;
    op_kind_e cur_kind;
    logic     wait_expired;
    logic     br_taken;

    assign dec_kind = classify(opcode);
    assign cur_kind = classify(op_q);

    // The low cycle that would bring wait_cnt to MEM_WAIT_MAX is the timeout cycle.
    assign wait_expired = !mem_ready && (wait_cnt_q == WAIT_W'(MEM_WAIT_MAX - 1));

    branch_cond_eval u_branch_cond (
        .cc    (op_q[1:0]),
        .flags (flags),
        .taken (br_taken)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_cnt_d = wait_cnt_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                case (dec_kind)
                    K_R_ALU, K_I_ALU, K_LOAD, K_STORE: state_d = S_EXEC;
                    K_BRANCH:                          state_d = S_BRANCH;
                    K_JAL:                             state_d = S_WB;
                    K_HALT:                            state_d = S_HALT;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC: state_d = (cur_kind == K_LOAD || cur_kind == K_STORE) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (cur_kind == K_LOAD) ? S_WB : S_FETCH;
                end else if (wait_expired) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_WB, S_BRANCH: state_d = S_FETCH;
            S_HALT:         state_d = S_HALT;
            default:        state_d = S_HALT;
        endcase

        // Counter restarts on every state change, so entry to FETCH/MEM always sees zero.
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RESET;
            op_q       <= '0;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Outputs decode from registered state/op; reset forces S_RESET so strobes drop at once.
    always_comb begin
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemtoReg  = 1'b0;
        DataPCSel = 1'b0;
        RegSelect = 1'b0;
        ALUop     = '0;
        ALUinSel  = ALUSRC_REG;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = PCSRC_INC;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    PCSrc   = PCSRC_INC;
                end
            end
            S_EXEC: begin
                if (cur_kind == K_R_ALU) begin
                    ALUop    = ALUOP_W'(op_q[2:0]);
                    ALUinSel = ALUSRC_REG;
                end else if (cur_kind == K_I_ALU) begin
                    ALUop    = ALUOP_W'(op_q[2:0]);
                    ALUinSel = ALUSRC_IMM;
                end else begin
                    ALUop    = ALUOP_W'(ALUOP_ADD);
                    ALUinSel = ALUSRC_IMM;
                end
            end
            S_MEM: begin
                MemRead  = (cur_kind == K_LOAD);
                MemWrite = (cur_kind == K_STORE);
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (cur_kind == K_LOAD);
                if (cur_kind == K_JAL) begin
                    DataPCSel = 1'b1;
                    RegSelect = 1'b1;
                    PCWrite   = 1'b1;
                    PCSrc     = PCSRC_JUMP;
                end
            end
            S_BRANCH: begin
                if (br_taken) begin
                    PCWrite = 1'b1;
                    PCSrc   = PCSRC_BRANCH;
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign illegal_op = illegal_q;
    assign bus_error  = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a per-cycle vector table plus
// hand-written sequences for memory waits, timeout, precedence and async reset.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       data_pc_sel;
        logic       reg_select;
        logic [2:0] alu_op;
        logic [1:0] alu_in_sel;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       halted;
        logic       illegal_op;
        logic       bus_error;
    } ctrl_t;

    typedef struct {
        logic [5:0] op;
        logic [2:0] fl;
        logic       rdy;
        ctrl_t      exp;
        string      name;
    } vec_t;

    localparam logic [5:0] OP_RADD = 6'b000010;
    localparam logic [5:0] OP_IALU = 6'b001101;
    localparam logic [5:0] OP_LD   = 6'b010000;
    localparam logic [5:0] OP_ST   = 6'b011000;
    localparam logic [5:0] OP_BZ   = 6'b100001;
    localparam logic [5:0] OP_BS   = 6'b100010;
    localparam logic [5:0] OP_BC   = 6'b100011;
    localparam logic [5:0] OP_BA   = 6'b100000;
    localparam logic [5:0] OP_JAL  = 6'b101000;
    localparam logic [5:0] OP_BAD  = 6'b110000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = '0;
    logic [2:0] flags = '0;
    logic       mem_ready = 1'b0;

    logic       RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect;
    logic [2:0] ALUop;
    logic [1:0] ALUinSel, PCSrc;
    logic       IRWrite, PCWrite, halted, illegal_op, bus_error;

    ctrl_t act;
    vec_t  tbl[$];
    int    vectors = 0;
    int    miscompares = 0;

    multicycle_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .flags      (flags),
        .mem_ready  (mem_ready),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .DataPCSel  (DataPCSel),
        .RegSelect  (RegSelect),
        .ALUop      (ALUop),
        .ALUinSel   (ALUinSel),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCSrc      (PCSrc),
        .halted     (halted),
        .illegal_op (illegal_op),
        .bus_error  (bus_error)
    );

    always #5 clk = ~clk;

    assign act = {RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect,
                  ALUop, ALUinSel, IRWrite, PCWrite, PCSrc, halted, illegal_op, bus_error};

    // Expected-output builders, one per FSM state.
    function automatic ctrl_t f_none();
        return '0;
    endfunction

    function automatic ctrl_t f_fetch(input logic rdy);
        ctrl_t e = '0;
        e.mem_read = 1'b1;
        e.ir_write = rdy;
        e.pc_write = rdy;
        return e;
    endfunction

    function automatic ctrl_t f_exec(input logic [2:0] aop, input logic [1:0] sel);
        ctrl_t e = '0;
        e.alu_op     = aop;
        e.alu_in_sel = sel;
        return e;
    endfunction

    function automatic ctrl_t f_mem(input logic rd, input logic wr);
        ctrl_t e = '0;
        e.mem_read  = rd;
        e.mem_write = wr;
        return e;
    endfunction

    function automatic ctrl_t f_wb(input logic load, input logic jal);
        ctrl_t e = '0;
        e.reg_write   = 1'b1;
        e.mem_to_reg  = load;
        e.data_pc_sel = jal;
        e.reg_select  = jal;
        e.pc_write    = jal;
        e.pc_src      = jal ? 2'b10 : 2'b00;
        return e;
    endfunction

    function automatic ctrl_t f_br(input logic taken);
        ctrl_t e = '0;
        e.pc_write = taken;
        e.pc_src   = taken ? 2'b01 : 2'b00;
        return e;
    endfunction

    function automatic ctrl_t f_halt(input logic ill, input logic bus);
        ctrl_t e = '0;
        e.halted     = 1'b1;
        e.illegal_op = ill;
        e.bus_error  = bus;
        return e;
    endfunction

    task automatic check(input string name, input ctrl_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic [2:0] fl, input logic rdy,
                       input ctrl_t exp, input string name);
        vec_t v;
        v.op = op; v.fl = fl; v.rdy = rdy; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    // Called at posedge+1: drive inputs, compare at negedge, advance one edge.
    task automatic step(input logic [5:0] op, input logic [2:0] fl, input logic rdy,
                        input ctrl_t exp, input string name);
        opcode    = op;
        flags     = fl;
        mem_ready = rdy;
        @(negedge clk);
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in S_FETCH at posedge+1.
    task automatic do_reset();
        reset     = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", f_none());
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_released", f_none());
        @(posedge clk);
        #1;
    endtask

    initial begin
        // R-ALU add-class op 010: 4 cycles, then next fetch.
        add(OP_RADD, 3'b000, 1'b1, f_fetch(1'b1),          "ralu_fetch");
        add(OP_RADD, 3'b000, 1'b1, f_none(),               "ralu_decode");
        add(OP_RADD, 3'b000, 1'b1, f_exec(3'b010, 2'b00),  "ralu_exec");
        add(OP_RADD, 3'b000, 1'b1, f_wb(1'b0, 1'b0),       "ralu_wb");
        add(OP_IALU, 3'b000, 1'b1, f_fetch(1'b1),          "ialu_fetch");
        add(OP_IALU, 3'b000, 1'b1, f_none(),               "ialu_decode");
        add(OP_IALU, 3'b111, 1'b1, f_exec(3'b101, 2'b01),  "ialu_exec");
        add(OP_IALU, 3'b000, 1'b1, f_wb(1'b0, 1'b0),       "ialu_wb");
        add(OP_ST,   3'b000, 1'b1, f_fetch(1'b1),          "store_fetch");
        add(OP_ST,   3'b000, 1'b1, f_none(),               "store_decode");
        add(6'h3f,   3'b000, 1'b1, f_exec(3'b000, 2'b01),  "store_exec");
        add(6'h3f,   3'b000, 1'b1, f_mem(1'b0, 1'b1),      "store_mem");
        add(OP_BZ,   3'b000, 1'b1, f_fetch(1'b1),          "bz_fetch");
        add(OP_BZ,   3'b000, 1'b1, f_none(),               "bz_decode");
        add(OP_BZ,   3'b001, 1'b1, f_br(1'b1),             "bz_taken");
        add(OP_BZ,   3'b001, 1'b1, f_fetch(1'b1),          "bz2_fetch");
        add(OP_BZ,   3'b111, 1'b1, f_none(),               "bz2_decode");
        add(OP_BZ,   3'b000, 1'b1, f_br(1'b0),             "bz_not_taken");
        add(OP_BS,   3'b000, 1'b1, f_fetch(1'b1),          "bs_fetch");
        add(OP_BS,   3'b000, 1'b1, f_none(),               "bs_decode");
        add(OP_BS,   3'b010, 1'b1, f_br(1'b1),             "bs_taken");
        add(OP_BC,   3'b000, 1'b1, f_fetch(1'b1),          "bc_fetch");
        add(OP_BC,   3'b100, 1'b1, f_none(),               "bc_decode");
        add(OP_BC,   3'b011, 1'b1, f_br(1'b0),             "bc_not_taken");
        add(OP_BA,   3'b000, 1'b1, f_fetch(1'b1),          "ba_fetch");
        add(OP_BA,   3'b000, 1'b1, f_none(),               "ba_decode");
        add(OP_BA,   3'b000, 1'b1, f_br(1'b1),             "ba_always");
        add(OP_JAL,  3'b000, 1'b1, f_fetch(1'b1),          "jal_fetch");
        add(OP_JAL,  3'b000, 1'b1, f_none(),               "jal_decode");
        add(OP_JAL,  3'b000, 1'b1, f_wb(1'b0, 1'b1),       "jal_wb");
        add(OP_LD,   3'b000, 1'b1, f_fetch(1'b1),          "load_fetch");
        add(OP_LD,   3'b000, 1'b1, f_none(),               "load_decode");
        add(OP_LD,   3'b000, 1'b1, f_exec(3'b000, 2'b01),  "load_exec");
        add(OP_LD,   3'b000, 1'b1, f_mem(1'b1, 1'b0),      "load_mem");
        add(OP_LD,   3'b000, 1'b1, f_wb(1'b1, 1'b0),       "load_wb");
        add(OP_BAD,  3'b000, 1'b1, f_fetch(1'b1),          "bad_fetch");
        add(OP_BAD,  3'b000, 1'b1, f_none(),               "bad_decode");
        add(OP_RADD, 3'b001, 1'b1, f_halt(1'b1, 1'b0),     "illegal_halt");
        add(OP_JAL,  3'b111, 1'b0, f_halt(1'b1, 1'b0),     "illegal_stays");

        do_reset();
        foreach (tbl[i]) step(tbl[i].op, tbl[i].fl, tbl[i].rdy, tbl[i].exp, tbl[i].name);

        // LOAD with three not-ready cycles in S_MEM.
        do_reset();
        step(OP_LD, 3'b000, 1'b1, f_fetch(1'b1), "ldw_fetch");
        step(OP_LD, 3'b000, 1'b1, f_none(), "ldw_decode");
        step(OP_LD, 3'b000, 1'b1, f_exec(3'b000, 2'b01), "ldw_exec");
        for (int i = 0; i < 3; i++) step(OP_LD, 3'b000, 1'b0, f_mem(1'b1, 1'b0), "ldw_mem_wait");
        step(OP_LD, 3'b000, 1'b1, f_mem(1'b1, 1'b0), "ldw_mem_ready");
        step(OP_LD, 3'b000, 1'b1, f_wb(1'b1, 1'b0), "ldw_wb");
        step(OP_LD, 3'b000, 1'b1, f_fetch(1'b1), "ldw_next_fetch");

        // mem_ready arriving on the last allowed cycle beats the timeout; MEM restarts the count.
        do_reset();
        for (int i = 0; i < 14; i++) step(OP_ST, 3'b000, 1'b0, f_fetch(1'b0), "prec_fetch_wait");
        step(OP_ST, 3'b000, 1'b1, f_fetch(1'b1), "prec_fetch_ready");
        step(OP_ST, 3'b000, 1'b1, f_none(), "prec_decode");
        step(OP_ST, 3'b000, 1'b1, f_exec(3'b000, 2'b01), "prec_exec");
        for (int i = 0; i < 3; i++) step(OP_ST, 3'b000, 1'b0, f_mem(1'b0, 1'b1), "prec_mem_wait");

        // Asynchronous reset mid-instruction drops the write strobe without a clock edge.
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_mid_mem", f_none());

        // Fetch timeout after 15 not-ready cycles.
        do_reset();
        for (int i = 0; i < 15; i++) step(OP_RADD, 3'b000, 1'b0, f_fetch(1'b0), "to_fetch_wait");
        step(OP_RADD, 3'b000, 1'b0, f_halt(1'b0, 1'b1), "timeout_halt");
        step(OP_RADD, 3'b000, 1'b1, f_halt(1'b0, 1'b1), "timeout_terminal");

        #2;
        reset = 1'b0;
        #1;
        check("async_reset_clears_sticky", f_none());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
